// File: rtl/dut_ctrl_loader_pkg.sv
// Shared definitions for the DUT controller loader: target set encoding,
// FSM state encoding, image geometry and the 256-bit image payload type.
package dut_ctrl_loader_pkg;

  localparam int unsigned WORDS   = 8;    // 32-bit words per 256-bit image
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned HALF_W  = 128;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned TGT_W   = 2;
  localparam int unsigned NUM_TGT = 4;

  localparam logic [TGT_W-1:0] TGT_SIG      = 2'd0;
  localparam logic [TGT_W-1:0] TGT_FF       = 2'd1;
  localparam logic [TGT_W-1:0] TGT_TEMPLATE = 2'd2;
  localparam logic [TGT_W-1:0] TGT_CYCLE    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_LOAD = 2'd2,
    ST_XFER = 2'd3
  } state_e;

  // Full image as seen by the controller: hi drives BUS128_1, lo drives BUS128_0.
  typedef struct packed {
    logic [HALF_W-1:0] hi;
    logic [HALF_W-1:0] lo;
  } image_t;

  // One-hot select of a target register set.
  function automatic logic [NUM_TGT-1:0] tgt_onehot(input logic [TGT_W-1:0] tgt);
    return NUM_TGT'(1) << tgt;
  endfunction

endpackage

// File: rtl/dut_ctrl_loader_packer.sv
// bus_word_packer: word counter plus the 256-bit word-indexed image register.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   wr           write data into the slot addressed by the counter, advance counter
//   clr          return counter to slot 0 (image contents are kept)
//   data         32-bit word to write
//   img          registered 256-bit image (word k at bits [32k+31:32k])
//   full_c       counter addresses the last slot (next write completes the image)
module bus_word_packer
  import dut_ctrl_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic              clr,
  input  logic [WORD_W-1:0] data,
  output image_t            img,
  output logic              full_c
);

  logic [CNT_W-1:0] count;

  // Counter wraps naturally to 0 after the 8th word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      img   <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (wr) begin
      img[{count, 5'd0} +: WORD_W] <= data;
      count                        <= count + CNT_W'(1);
    end
  end

  assign full_c = (count == CNT_W'(WORDS - 1));

endmodule

// File: rtl/dut_ctrl_loader.sv
// dut_ctrl_loader: packs host words into the controller's two 128-bit load
// buses and sequences per-set LOAD / TRANSFER strobes.
// Ports:
//   CLK, RST            clock, asynchronous active-high reset
//   WR_EN/WR_DATA       host word (accepted while READY=1)
//   WR_TARGET           register set of the image: SIG, FF, TEMPLATE, CYCLE
//   COMMIT              transfer every pending set
//   ABORT               discard the partially filled image
//   READY               loader accepts words (IDLE/FILL)
//   BUS128_0/BUS128_1   image low/high halves
//   *_LOAD, *_TRANSFER  one-cycle strobes per register set
//   PENDING             sets loaded but not yet transferred
//   ERR                 sticky protocol error
module dut_ctrl_loader
  import dut_ctrl_loader_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              WR_EN,
  input  logic [WORD_W-1:0] WR_DATA,
  input  logic [TGT_W-1:0]  WR_TARGET,
  input  logic              COMMIT,
  input  logic              ABORT,
  output logic              READY,
  output logic [HALF_W-1:0] BUS128_0,
  output logic [HALF_W-1:0] BUS128_1,
  output logic              SIG_LOAD,
  output logic              FF_LOAD,
  output logic              TEMPLATE_LOAD,
  output logic              CYCLE_LOAD,
  output logic              SIG_TRANSFER,
  output logic              FF_TRANSFER,
  output logic              TEMPLATE_TRANSFER,
  output logic              CYCLE_TRANSFER,
  output logic [NUM_TGT-1:0] PENDING,
  output logic              ERR
);

  state_e               state_q, state_d;
  logic [TGT_W-1:0]     tgt_q, tgt_d;
  logic                 latch_q, latch_d;
  logic [NUM_TGT-1:0]   pending_q, pending_d;
  logic                 err_q, err_d;
  logic [NUM_TGT-1:0]   load_q, load_d;
  logic [NUM_TGT-1:0]   xfer_q, xfer_d;
  logic                 ready_q, ready_d;
  logic                 pk_wr_c, pk_clr_c, pk_full_c;
  image_t               img;

  bus_word_packer u_packer (
    .clk    (CLK),
    .rst    (RST),
    .wr     (pk_wr_c),
    .clr    (pk_clr_c),
    .data   (WR_DATA),
    .img    (img),
    .full_c (pk_full_c)
  );

  // State and registered outputs; reset drops every strobe immediately.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      tgt_q     <= TGT_SIG;
      latch_q   <= 1'b0;
      pending_q <= '0;
      err_q     <= 1'b0;
      load_q    <= '0;
      xfer_q    <= '0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      latch_q   <= latch_d;
      pending_q <= pending_d;
      err_q     <= err_d;
      load_q    <= load_d;
      xfer_q    <= xfer_d;
      ready_q   <= ready_d;
    end
  end

  // Next-state, packer control and next values of the registered outputs.
  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    latch_d   = latch_q;
    pending_d = pending_q;
    err_d     = err_q;
    pk_wr_c   = 1'b0;
    pk_clr_c  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (WR_EN) begin
          // A word wins over a latched commit; the latch survives into the fill.
          pk_wr_c = 1'b1;
          tgt_d   = WR_TARGET;
          state_d = ST_FILL;
          if (COMMIT) latch_d = 1'b1;
        end else if (COMMIT || latch_q) begin
          latch_d = 1'b0;
          if (pending_q != '0) state_d = ST_XFER;
        end
      end
      ST_FILL: begin
        if (COMMIT) latch_d = 1'b1;
        if (ABORT) begin
          // Abort also swallows a coincident word without flagging an error.
          pk_clr_c = 1'b1;
          state_d  = ST_IDLE;
        end else if (WR_EN) begin
          if (WR_TARGET == tgt_q) begin
            pk_wr_c = 1'b1;
            if (pk_full_c) state_d = ST_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (COMMIT) latch_d = 1'b1;
        if (WR_EN)  err_d   = 1'b1;
        state_d = ST_IDLE;
      end
      ST_XFER: begin
        if (WR_EN) err_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Strobes and PENDING update on the edge that enters LOAD / XFER.
    load_d  = (state_d == ST_LOAD) ? tgt_onehot(tgt_d) : '0;
    xfer_d  = (state_d == ST_XFER) ? pending_q : '0;
    if (state_d == ST_LOAD) pending_d = pending_q | tgt_onehot(tgt_d);
    if (state_d == ST_XFER) pending_d = '0;
    ready_d = (state_d == ST_IDLE) || (state_d == ST_FILL);
  end

  assign READY             = ready_q;
  assign BUS128_0          = img.lo;
  assign BUS128_1          = img.hi;
  assign SIG_LOAD          = load_q[TGT_SIG];
  assign FF_LOAD           = load_q[TGT_FF];
  assign TEMPLATE_LOAD     = load_q[TGT_TEMPLATE];
  assign CYCLE_LOAD        = load_q[TGT_CYCLE];
  assign SIG_TRANSFER      = xfer_q[TGT_SIG];
  assign FF_TRANSFER       = xfer_q[TGT_FF];
  assign TEMPLATE_TRANSFER = xfer_q[TGT_TEMPLATE];
  assign CYCLE_TRANSFER    = xfer_q[TGT_CYCLE];
  assign PENDING           = pending_q;
  assign ERR               = err_q;

endmodule

// File: tb/tb_dut_ctrl_loader.sv
// Directed bench for dut_ctrl_loader: hand-computed bus images, strobe timing,
// commit latch, abort, target mismatch and reset-during-strobe.
module tb_dut_ctrl_loader;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         WR_EN = 1'b0;
  logic [31:0]  WR_DATA = '0;
  logic [1:0]   WR_TARGET = '0;
  logic         COMMIT = 1'b0;
  logic         ABORT = 1'b0;
  logic         READY;
  logic [127:0] BUS128_0, BUS128_1;
  logic         SIG_LOAD, FF_LOAD, TEMPLATE_LOAD, CYCLE_LOAD;
  logic         SIG_TRANSFER, FF_TRANSFER, TEMPLATE_TRANSFER, CYCLE_TRANSFER;
  logic [3:0]   PENDING;
  logic         ERR;

  int vectors = 0;
  int miscompares = 0;
  int sig_loads = 0;
  int sig_snap;

  dut_ctrl_loader dut (
    .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .WR_DATA(WR_DATA), .WR_TARGET(WR_TARGET),
    .COMMIT(COMMIT), .ABORT(ABORT), .READY(READY),
    .BUS128_0(BUS128_0), .BUS128_1(BUS128_1),
    .SIG_LOAD(SIG_LOAD), .FF_LOAD(FF_LOAD), .TEMPLATE_LOAD(TEMPLATE_LOAD), .CYCLE_LOAD(CYCLE_LOAD),
    .SIG_TRANSFER(SIG_TRANSFER), .FF_TRANSFER(FF_TRANSFER),
    .TEMPLATE_TRANSFER(TEMPLATE_TRANSFER), .CYCLE_TRANSFER(CYCLE_TRANSFER),
    .PENDING(PENDING), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  wire [3:0] loads = {CYCLE_LOAD, TEMPLATE_LOAD, FF_LOAD, SIG_LOAD};
  wire [3:0] xfers = {CYCLE_TRANSFER, TEMPLATE_TRANSFER, FF_TRANSFER, SIG_TRANSFER};

  // Count SIG_LOAD cycles mid-cycle.
  always @(negedge CLK) if (SIG_LOAD === 1'b1) sig_loads++;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_word(input logic [31:0] d, input logic [1:0] t);
    WR_EN = 1'b1; WR_DATA = d; WR_TARGET = t;
    step();
    WR_EN = 1'b0;
  endtask

  // Eight words base+i; COMMIT pulses alongside word commit_idx (-1: none).
  task automatic load_image(input logic [31:0] base, input logic [1:0] t, input int commit_idx);
    for (int i = 0; i < 8; i++) begin
      WR_EN = 1'b1; WR_DATA = base + 32'(i); WR_TARGET = t;
      COMMIT = (i == commit_idx);
      step();
    end
    WR_EN = 1'b0; COMMIT = 1'b0;
  endtask

  task automatic pulse_commit();
    COMMIT = 1'b1;
    step();
    COMMIT = 1'b0;
  endtask

  initial begin
    // Reset values
    #12;
    check("rst_ready", 128'(READY), 128'd1);
    check("rst_bus0", BUS128_0, 128'd0);
    check("rst_bus1", BUS128_1, 128'd0);
    check("rst_loads", 128'(loads), 128'd0);
    check("rst_xfers", 128'(xfers), 128'd0);
    check("rst_pending", 128'(PENDING), 128'd0);
    check("rst_err", 128'(ERR), 128'd0);
    @(negedge CLK) RST = 1'b0;

    // FF image 0x11111111..0x88888888
    for (int i = 0; i < 8; i++) send_word(32'h11111111 * 32'(i + 1), 2'd1);
    check("t1_loads", 128'(loads), 128'b0010);
    check("t1_pending", 128'(PENDING), 128'b0010);
    check("t1_ready", 128'(READY), 128'd0);
    check("t1_xfers", 128'(xfers), 128'd0);
    check("t1_bus0", BUS128_0, 128'h44444444_33333333_22222222_11111111);
    check("t1_bus1", BUS128_1, 128'h88888888_77777777_66666666_55555555);
    step();
    check("t1_loads_off", 128'(loads), 128'd0);
    check("t1_ready_back", 128'(READY), 128'd1);
    check("t1_pending_hold", 128'(PENDING), 128'b0010);
    pulse_commit();
    check("t1_ff_xfer", 128'(xfers), 128'b0010);
    check("t1_pending_clr", 128'(PENDING), 128'd0);
    step();
    check("t1_xfer_off", 128'(xfers), 128'd0);

    // SIG then CYCLE, commit in IDLE
    load_image(32'h5000_0000, 2'd0, -1);
    check("t2_sig_load", 128'(loads), 128'b0001);
    step();
    load_image(32'h6000_0000, 2'd3, -1);
    check("t2_cyc_load", 128'(loads), 128'b1000);
    check("t2_pending", 128'(PENDING), 128'b1001);
    check("t2_bus1", BUS128_1, 128'h60000007_60000006_60000005_60000004);
    step();
    pulse_commit();
    check("t2_xfers", 128'(xfers), 128'b1001);
    check("t2_no_load", 128'(loads), 128'd0);
    check("t2_pending_clr", 128'(PENDING), 128'd0);
    step();
    check("t2_xfer_off", 128'(xfers), 128'd0);

    // COMMIT during word 5 of a TEMPLATE fill
    load_image(32'h3000_0000, 2'd2, 4);
    check("t3_tmpl_load", 128'(loads), 128'b0100);
    check("t3_no_xfer_load", 128'(xfers), 128'd0);
    step();
    check("t3_no_xfer_idle", 128'(xfers), 128'd0);
    check("t3_pending", 128'(PENDING), 128'b0100);
    step();
    check("t3_tmpl_xfer", 128'(xfers), 128'b0100);
    check("t3_pending_clr", 128'(PENDING), 128'd0);
    step();
    check("t3_xfer_off", 128'(xfers), 128'd0);

    // 3 words, ABORT with a coincident mismatched word, then a full SIG image
    sig_snap = sig_loads;
    for (int i = 0; i < 3; i++) send_word(32'hA000_0000 + 32'(i), 2'd0);
    ABORT = 1'b1; WR_EN = 1'b1; WR_DATA = 32'hFFFF_FFFF; WR_TARGET = 2'd1;
    step();
    ABORT = 1'b0; WR_EN = 1'b0;
    check("t4_abort_err", 128'(ERR), 128'd0);
    check("t4_abort_ready", 128'(READY), 128'd1);
    check("t4_abort_loads", 128'(loads), 128'd0);
    load_image(32'hB000_0000, 2'd0, -1);
    check("t4_bus0", BUS128_0, 128'hB0000003_B0000002_B0000001_B0000000);
    step();
    check("t4_sig_load_count", 128'(sig_loads - sig_snap), 128'd1);

    // Mismatched target at word 4
    for (int i = 0; i < 4; i++) send_word(32'hC000_0000 + 32'(i), 2'd1);
    send_word(32'hDEAD_BEEF, 2'd0);
    check("t5_err", 128'(ERR), 128'd1);
    check("t5_dropped", BUS128_1, 128'hB0000007_B0000006_B0000005_B0000004);
    for (int i = 4; i < 8; i++) send_word(32'hC000_0000 + 32'(i), 2'd1);
    check("t5_ff_load", 128'(loads), 128'b0010);
    check("t5_bus0", BUS128_0, 128'hC0000003_C0000002_C0000001_C0000000);
    check("t5_bus1", BUS128_1, 128'hC0000007_C0000006_C0000005_C0000004);
    step();
    check("t5_err_sticky", 128'(ERR), 128'd1);

    // Reset during the LOAD cycle
    load_image(32'h7000_0000, 2'd1, -1);
    check("t6_ff_load", 128'(loads), 128'b0010);
    RST = 1'b1;
    #1;
    check("t6_load_drop", 128'(loads), 128'd0);
    check("t6_bus0", BUS128_0, 128'd0);
    check("t6_bus1", BUS128_1, 128'd0);
    check("t6_pending", 128'(PENDING), 128'd0);
    check("t6_err", 128'(ERR), 128'd0);
    check("t6_ready", 128'(READY), 128'd1);
    @(negedge CLK) RST = 1'b0;
    pulse_commit();
    check("t6_no_xfer", 128'(xfers), 128'd0);
    check("t6_ready_idle", 128'(READY), 128'd1);
    step();
    check("t6_no_xfer2", 128'(xfers), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dut_ctrl_loader.md
# dut_ctrl_loader

Host-side loader that sits directly upstream of the DUT controller. It packs 32-bit host words into the controller's two 128-bit load buses, BUS128_0 and BUS128_1. It also sequences the per-register LOAD and TRANSFER strobes for the four controller register sets: SIG, FF, TEMPLATE and CYCLE. Buses are held stable around every strobe, so the controller always samples a complete 256-bit image.

## Interface
Parameters:
- WORDS, 8, 32-bit words per 256-bit image (fixed; words 0-3 → BUS128_0, 4-7 → BUS128_1)

Ports:
- CLK  in  1  system clock; all logic on rising edge
- RST  in  1  asynchronous, active-high reset
- WR_EN  in  1  host word valid; accepted only when READY=1
- WR_DATA  in  32  host data word
- WR_TARGET  in  2  target register set: 0=SIG, 1=FF, 2=TEMPLATE, 3=CYCLE
- COMMIT  in  1  one-cycle pulse: transfer all pending loaded sets
- ABORT  in  1  one-cycle pulse: discard partial image
- READY  out  1  loader can accept a word
- BUS128_0  out  128  image low half
- BUS128_1  out  128  image high half
- SIG_LOAD, FF_LOAD, TEMPLATE_LOAD, CYCLE_LOAD  out  1 each  one-cycle load strobes
- SIG_TRANSFER, FF_TRANSFER, TEMPLATE_TRANSFER, CYCLE_TRANSFER  out  1 each  one-cycle transfer strobes
- PENDING  out  4  bit per target set: loaded, not yet transferred
- ERR  out  1  sticky protocol error; cleared only by RST

## Operation
- FSM states: IDLE, FILL, LOAD, XFER.
- IDLE:
  - An accepted word latches WR_TARGET as the current target, writes slot 0, sets the word counter to 1 and moves to FILL.
  - COMMIT (or a latched commit) with PENDING≠0 moves to XFER.
  - COMMIT with PENDING=0 is a no-op.
- FILL:
  - Word k is written to bits [32(k mod 4)+31 : 32(k mod 4)] of BUS128_0 (k<4) or BUS128_1 (k≥4).
  - The counter is 3 bits. The 8th accepted word moves to LOAD.
  - A word whose WR_TARGET differs from the latched target is dropped and sets ERR. The counter is unchanged.
  - ABORT returns to IDLE with counter=0. No strobe is issued. Bus contents are left as-is (don't-care for the controller).
- LOAD:
  - Exactly one of the four *_LOAD strobes is high for one cycle, selected by the latched target.
  - The matching PENDING bit is set.
  - Next state is IDLE.
- XFER:
  - *_TRANSFER is high for one cycle for every set PENDING bit, all simultaneously.
  - PENDING clears to 0. Next state is IDLE.
- Commit latch: a COMMIT seen in FILL or LOAD, or coincident with an accepted word in IDLE, sets a latch. The latch is consumed on the next cycle spent in IDLE.
- READY=1 in IDLE and FILL; 0 in LOAD and XFER.
- WR_EN while READY=0 is ignored and sets ERR.
- ABORT in IDLE, LOAD or XFER is a no-op. An in-flight strobe still completes.
- Simultaneous ABORT and WR_EN in FILL: ABORT wins and the word is dropped. No ERR is raised.
- Reloading a target that is already pending: the new LOAD overwrites the controller's staging. PENDING stays set.

## Timing
- Reset values: state IDLE, READY=1, both buses 0, all strobes 0, PENDING=0, ERR=0, counter 0, commit latch 0.
- RST mid-image or mid-strobe aborts immediately. Strobes drop asynchronously.
- Word-to-bus latency is 1 cycle (registered).
- *_LOAD is asserted in the cycle after the 8th word is accepted. Bus values are stable from that word's write edge through the strobe cycle and until the next accepted word.
- *_TRANSFER is asserted in the cycle after COMMIT is sampled in IDLE. For a latched commit, it is asserted one cycle after re-entering IDLE.
- Minimum image throughput: 8 words + 1 LOAD cycle = 9 cycles per image.
- Strobes are never high for more than one consecutive cycle. LOAD and TRANSFER are never asserted in the same cycle.

## Structure
- Shared package: target encoding constants (TGT_SIG…TGT_CYCLE), state encoding, and WORDS.
- One natural sub-module, `bus_word_packer`: the 3-bit counter plus the 256-bit word-indexed register, with write, clear and full outputs.
- The FSM, commit latch, PENDING, ERR and strobe decode live in dut_ctrl_loader.

## Test plan
- Reset then 8 words 0x11111111…0x88888888 with target FF:
  - BUS128_0 = 0x44444444_33333333_22222222_11111111
  - BUS128_1 = 0x88888888_77777777_66666666_55555555
  - FF_LOAD pulses 1 cycle after the 8th word
  - PENDING=4'b0010
- Load SIG then CYCLE, then COMMIT in IDLE → SIG_TRANSFER and CYCLE_TRANSFER both high for exactly one cycle, then PENDING=0.
- COMMIT during word 5 of a TEMPLATE fill → no transfer until the load completes. TEMPLATE_TRANSFER fires one cycle after returning to IDLE.
- 3 words, then ABORT, then 8 new words (target SIG) → only one SIG_LOAD. Words 0-2 come from the second image.
- Word 4 sent with a mismatched target → ERR=1 and the word is dropped. The image completes after 8 valid words. ERR stays 1 until RST.
- RST asserted in the LOAD cycle → strobe drops immediately and all outputs return to reset values. COMMIT with PENDING=0 produces no transfer.
